// File: rtl/demux_router_pkg.sv
// Shared constants and FSM encoding for the 1:4 packet demux router.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_router_pkg;

    localparam int NUM_OUT = 4;
    localparam int DEST_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

endpackage

// File: rtl/demux_out_slot.sv
// Single-entry registered output buffer holding {data, last, dest}.
// Latency: 1 cycle from load to full.
// Backpressure: holds contents while full and not drained; load wins over drain.
module demux_out_slot
    import demux_router_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic [DEST_W-1:0] load_dest,
    input  logic              drain,
    output logic              full,
    output logic [DEST_W-1:0] slot_dest,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 1'b0;
            slot_dest <= '0;
            data      <= '0;
            last      <= 1'b0;
        end else if (load) begin
            // A load in the same cycle as a drain replaces the departing beat.
            full      <= 1'b1;
            slot_dest <= load_dest;
            data      <= load_data;
            last      <= load_last;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_stream_router_1to4.sv
// 1:4 packet demux: destination locked on the first beat, disabled destinations drained and counted.
// Latency: 1 cycle from input accept to m_valid through a single registered slot.
// Backpressure: s_ready follows the slot (combinational on m_ready); dropped packets never stall.
module demux_stream_router_1to4
    import demux_router_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DATA_W-1:0]  s_data,
    input  logic [DEST_W-1:0]  s_dest,
    input  logic               s_last,
    input  logic [NUM_OUT-1:0] en_mask,
    output logic [NUM_OUT-1:0] m_valid,
    input  logic [NUM_OUT-1:0] m_ready,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_last,
    output logic               busy,
    output logic [CNT_W-1:0]   drop_count
);

    state_t            state, state_nxt;
    logic [DEST_W-1:0] lock_dest, lock_nxt;
    logic [DEST_W-1:0] load_dest;
    logic [DEST_W-1:0] slot_dest;
    logic              full, drain, slot_free;
    logic              load, drop_inc, ready_int;

    assign drain     = full & m_ready[slot_dest];
    assign slot_free = ~full | drain;

    always_comb begin
        state_nxt = state;
        lock_nxt  = lock_dest;
        load_dest = lock_dest;
        ready_int = 1'b0;
        load      = 1'b0;
        drop_inc  = 1'b0;
        case (state)
            IDLE: begin
                if (en_mask[s_dest]) begin
                    ready_int = slot_free;
                    if (s_valid && slot_free) begin
                        load      = 1'b1;
                        load_dest = s_dest;
                        lock_nxt  = s_dest;
                        if (!s_last) state_nxt = FWD;
                    end
                end else begin
                    ready_int = 1'b1;
                    if (s_valid) begin
                        if (s_last) drop_inc  = 1'b1;
                        else        state_nxt = DROP;
                    end
                end
            end
            FWD: begin
                ready_int = slot_free;
                if (s_valid && slot_free) begin
                    load = 1'b1;
                    if (s_last) state_nxt = IDLE;
                end
            end
            DROP: begin
                ready_int = 1'b1;
                if (s_valid && s_last) begin
                    drop_inc  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lock_dest  <= '0;
            drop_count <= '0;
        end else begin
            state     <= state_nxt;
            lock_dest <= lock_nxt;
            if (drop_inc && (drop_count != {CNT_W{1'b1}}))
                drop_count <= drop_count + CNT_W'(1);
        end
    end

    demux_out_slot #(.DATA_W(DATA_W)) u_slot (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (s_data),
        .load_last (s_last),
        .load_dest (load_dest),
        .drain     (drain),
        .full      (full),
        .slot_dest (slot_dest),
        .data      (m_data),
        .last      (m_last)
    );

    always_comb begin
        m_valid = '0;
        for (int i = 0; i < NUM_OUT; i++)
            m_valid[i] = full && (slot_dest == DEST_W'(i));
    end

    // Reset must hold off the producer even though the FSM would otherwise say ready.
    assign s_ready = rst_n & ready_int;
    assign busy    = (state != IDLE) | full;

endmodule

// File: tb/tb_demux_stream_router_1to4.sv
// Bench for demux_stream_router_1to4: vector table plus handshake sequences, scoreboarded outputs.
module tb_demux_stream_router_1to4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] s_data = '0;
    logic [1:0] s_dest = '0;
    logic       s_last = 1'b0;
    logic [3:0] en_mask = 4'hF;
    logic [3:0] m_valid;
    logic [3:0] m_ready = 4'hF;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;
    logic [7:0] drop_count;

    demux_stream_router_1to4 #(.DATA_W(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_dest     (s_dest),
        .s_last     (s_last),
        .en_mask    (en_mask),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] dest;
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic [3:0] en;
        logic [1:0] dest;
        logic [7:0] data;
        logic [3:0] exp_mvalid;
        logic [7:0] exp_drop;
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    beat_t sb[$];
    int    last_stalls = 0;

    // Reference packet model
    logic       in_pkt = 1'b0;
    logic       pkt_fwd = 1'b0;
    logic [1:0] pkt_dest = '0;
    int         exp_drop = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one beat and returns just after the posedge that accepts it.
    task automatic send_beat(input logic [7:0] d, input logic [1:0] dst, input logic l);
        int waits = 0;
        s_valid = 1'b1; s_data = d; s_dest = dst; s_last = l;
        @(negedge clk);
        while (!s_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (!s_ready) begin
            checks++; failures++;
            $display("FAIL send_beat_timeout: s_ready got 0 expected 1 data=0x%0h", d);
        end else begin
            if (!in_pkt) begin
                pkt_fwd  = en_mask[dst];
                pkt_dest = dst;
            end
            if (pkt_fwd) sb.push_back('{dest: pkt_dest, data: d, last: l});
            if (l) begin
                in_pkt = 1'b0;
                if (!pkt_fwd && exp_drop < 255) exp_drop++;
            end else begin
                in_pkt = 1'b1;
            end
        end
        @(posedge clk); #1;
        s_valid = 1'b0;
        last_stalls = waits;
    endtask

    // Output monitor: every handshaking output beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(m_valid) > 1) begin
                failures++;
                $display("FAIL onehot: m_valid got %b expected at most one bit", m_valid);
            end
            for (int i = 0; i < 4; i++) begin
                if (m_valid[i] && m_ready[i]) begin
                    if (sb.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL sb_unexpected: got port %0d data 0x%0h expected no beat", i, m_data);
                    end else begin
                        beat_t e;
                        e = sb.pop_front();
                        chk("sb_port", 32'(i), 32'(e.dest));
                        chk("sb_data", 32'(m_data), 32'(e.data));
                        chk("sb_last", 32'(m_last), 32'(e.last));
                    end
                end
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'hF,    2'd0, 8'hA0, 4'b0001, 8'd0};
        vecs[1] = '{4'hF,    2'd1, 8'hA1, 4'b0010, 8'd0};
        vecs[2] = '{4'hF,    2'd2, 8'hA2, 4'b0100, 8'd0};
        vecs[3] = '{4'hF,    2'd3, 8'hA3, 4'b1000, 8'd0};
        vecs[4] = '{4'b1110, 2'd0, 8'hA4, 4'b0000, 8'd1};
        vecs[5] = '{4'b0111, 2'd3, 8'hA5, 4'b0000, 8'd2};
        vecs[6] = '{4'b0111, 2'd2, 8'hA6, 4'b0100, 8'd2};
        vecs[7] = '{4'b1000, 2'd3, 8'hA7, 4'b1000, 8'd2};

        // Reset values
        #12;
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_data", 32'(m_data), 32'h0);
        chk("rst_m_last", 32'(m_last), 32'h0);
        chk("rst_drop", 32'(drop_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_s_ready", 32'(s_ready), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(2);

        // Single-beat packets, back-to-back, mixed enables
        for (int k = 0; k < 8; k++) begin
            en_mask = vecs[k].en;
            send_beat(vecs[k].data, vecs[k].dest, 1'b1);
            chk("vec_m_valid", 32'(m_valid), 32'(vecs[k].exp_mvalid));
            chk("vec_drop", 32'(drop_count), 32'(vecs[k].exp_drop));
            chk("vec_stall", 32'(last_stalls), 32'h0);
        end
        en_mask = 4'hF;
        idle_cycles(2);
        chk("vec_drain", 32'(sb.size()), 32'h0);
        chk("vec_idle_busy", 32'(busy), 32'h0);

        // 3-beat packet to dest 2 at full rate
        send_beat(8'h11, 2'd2, 1'b0);
        chk("p3_first_mvalid", 32'(m_valid), 32'b0100);
        chk("p3_busy", 32'(busy), 32'h1);
        chk("p3_stall0", 32'(last_stalls), 32'h0);
        send_beat(8'h22, 2'd2, 1'b0);
        chk("p3_mvalid2", 32'(m_valid), 32'b0100);
        chk("p3_stall1", 32'(last_stalls), 32'h0);
        send_beat(8'h33, 2'd2, 1'b1);
        chk("p3_mvalid3", 32'(m_valid), 32'b0100);
        chk("p3_data3", 32'(m_data), 32'h33);
        chk("p3_last3", 32'(m_last), 32'h1);
        chk("p3_stall2", 32'(last_stalls), 32'h0);
        idle_cycles(1);
        chk("p3_done", 32'(m_valid), 32'h0);

        // Backpressure on dest 1 mid-packet
        send_beat(8'h41, 2'd1, 1'b0);
        send_beat(8'h42, 2'd1, 1'b0);
        m_ready = 4'b1101;
        s_valid = 1'b1; s_data = 8'h43; s_dest = 2'd1; s_last = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_s_ready", 32'(s_ready), 32'h0);
            chk("bp_m_data", 32'(m_data), 32'h42);
            chk("bp_m_valid", 32'(m_valid), 32'b0010);
            @(posedge clk); #1;
        end
        m_ready = 4'hF;
        send_beat(8'h43, 2'd1, 1'b0);
        send_beat(8'h44, 2'd1, 1'b1);
        idle_cycles(2);
        chk("bp_drain", 32'(sb.size()), 32'h0);

        // Destination locked on first beat despite s_dest changing
        send_beat(8'h51, 2'd0, 1'b0);
        chk("lock_b1", 32'(m_valid), 32'b0001);
        for (int k = 2; k <= 4; k++) begin
            send_beat(8'h50 + 8'(k), 2'd3, (k == 4));
            chk("lock_bn", 32'(m_valid), 32'b0001);
        end
        idle_cycles(2);
        chk("lock_drain", 32'(sb.size()), 32'h0);

        // Drops: 2-beat and 1-beat to disabled dest 0; enable flip mid-packet ignored
        en_mask = 4'b1110;
        send_beat(8'h61, 2'd0, 1'b0);
        chk("drop_mvalid1", 32'(m_valid), 32'h0);
        chk("drop_stall1", 32'(last_stalls), 32'h0);
        en_mask = 4'hF;
        send_beat(8'h62, 2'd0, 1'b1);
        chk("drop_mvalid2", 32'(m_valid), 32'h0);
        chk("drop_stall2", 32'(last_stalls), 32'h0);
        en_mask = 4'b1110;
        send_beat(8'h63, 2'd0, 1'b1);
        chk("drop_mvalid3", 32'(m_valid), 32'h0);
        chk("drop_stall3", 32'(last_stalls), 32'h0);
        chk("drop_count2", 32'(drop_count), 32'(exp_drop));
        chk("drop_count_abs", 32'(drop_count), 32'd4);

        // Saturation
        for (int k = 0; k < 260; k++) send_beat(8'(k), 2'd0, 1'b1);
        chk("drop_sat_model", 32'(drop_count), 32'(exp_drop));
        chk("drop_sat", 32'(drop_count), 32'd255);
        send_beat(8'h70, 2'd0, 1'b1);
        chk("drop_sat_hold", 32'(drop_count), 32'd255);
        en_mask = 4'hF;

        // Async reset mid-packet to dest 3
        m_ready = 4'b0111;
        send_beat(8'h81, 2'd3, 1'b0);
        s_valid = 1'b1; s_data = 8'h82; s_dest = 2'd3; s_last = 1'b0;
        #2;
        chk("pre_rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_m_valid", 32'(m_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_s_ready", 32'(s_ready), 32'h0);
        chk("arst_drop", 32'(drop_count), 32'h0);
        sb.delete();
        in_pkt = 1'b0;
        exp_drop = 0;
        s_valid = 1'b0;
        m_ready = 4'hF;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(1);
        send_beat(8'h91, 2'd1, 1'b0);
        chk("post_rst_mvalid", 32'(m_valid), 32'b0010);
        send_beat(8'h92, 2'd1, 1'b1);
        chk("post_rst_mvalid2", 32'(m_valid), 32'b0010);
        idle_cycles(2);
        chk("post_rst_drain", 32'(sb.size()), 32'h0);
        chk("post_rst_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
